gate_bist_controller: RTL and testbench
=======================================

# gate_bist_controller

Built-in self-test sequencer for the basic gate library. Drives every input combination into one gate under test (NOT, BUF, or an N-input AND/OR/NAND/NOR/XOR/XNOR) and compares the gate's output against an internal reference model. Reports pass/fail, the mismatch count, and the first failing vector. It replaces hand-written per-gate stimulus with one reusable, synthesizable checker that wraps any gate instance.

## Interface
Parameters:
- `N_INPUTS`, default 2: gate input width; must be ≥1. NOT/BUF runs use bit 0 only.
- `SETTLE`, default 1: extra hold cycles per vector before the compare; 0 is legal.

Ports:
- `clk`, in, 1: single clock, all logic on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `start`, in, 1: request a run; sampled only in IDLE.
- `op`, in, 3: gate type, latched at start.
- `gate_in`, out, N_INPUTS: stimulus to the gate under test.
- `gate_out`, in, 1: gate under test response.
- `busy`, out, 1: high from start acceptance until DONE is exited.
- `done`, out, 1: one-cycle pulse at end of run.
- `pass`, out, 1: run result, held until next start.
- `fail_count`, out, N_INPUTS+1: number of mismatching vectors.
- `first_fail_vec`, out, N_INPUTS: first mismatching vector; 0 if none.

## Operation
- `op` encoding:
  - 0 BUF, 1 NOT: operate on `gate_in[0]`.
  - 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR: reductions over all N_INPUTS bits.
- States: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
- **IDLE**, with `start`=1:
  - Latch `op`.
  - `gate_in`←0, `cnt`←0, `fail_count`←0, `first_fail_vec`←0, `pass`←0.
  - `busy`←1, next state SETTLE.
- **SETTLE**: hold `gate_in`. If `cnt`==SETTLE go to CHECK, else `cnt`++.
- **CHECK**: compare `gate_out` against `expected(op_latched, gate_in)`.
  - On mismatch: `fail_count`++. If this is the first mismatch (`fail_count` was 0), record `first_fail_vec`←`gate_in`.
  - If `gate_in` is all ones, go to DONE.
  - Otherwise `gate_in`++, `cnt`←0, go to SETTLE.
- **DONE**: `done`=1 for this cycle only; `pass`←(`fail_count`==0); next state IDLE, where `busy`←0.
- `fail_count` cannot overflow: its maximum is 2^N_INPUTS, which fits in N_INPUTS+1 bits.
- Boundary conditions:
  - `start` while not in IDLE (including the DONE cycle) is ignored.
  - `op` changes during a run are ignored.
  - `gate_out` is sampled only in CHECK.
  - Vectors run in ascending order 0…2^N−1 with no wrap; the run ends at all ones.
  - `rst` mid-run returns to IDLE in one cycle and clears all outputs.

## Timing
- Reset values: `gate_in`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_vec`=0, state IDLE.
- Let E0 be the edge that samples `start`. `busy` and the first vector appear after E0.
- Each vector occupies SETTLE+2 cycles: SETTLE+1 in SETTLE, 1 in CHECK.
- `done` is high in the cycle after edge E0 + 2^N_INPUTS·(SETTLE+2).
- `pass` is valid from that cycle onward.
- `busy` falls one cycle after `done`.
- The earliest next start is sampled in the first IDLE cycle.

## Structure
- Shared include `gate_ops.vh`: op code defines (`OP_BUF` … `OP_XNOR`) and state encodings; reused by gate testbenches.
- Sub-module `gate_ref_model`: purely combinational, (`op`, `in[N_INPUTS-1:0]`) → `expected`.
- Controller FSM, vector counter and settle counter live in `gate_bist_controller`.

## Test plan
- **NOT passes.** N_INPUTS=1, SETTLE=1, correct `not_gate` wired in, `op`=1, pulse `start` → `gate_in` sequence 0,1; `done` at E0+6; `pass`=1, `fail_count`=0.
- **Stuck-at-0 AND.** N_INPUTS=2, `op`=2, `gate_out` tied to 0 → `fail_count`=1, `first_fail_vec`=2'b11, `pass`=0, `done` at E0+12.
- **Inverted XOR.** N_INPUTS=3, `op`=6, model wired as XNOR → `fail_count`=8, `first_fail_vec`=0, `pass`=0.
- **Zero settle.** SETTLE=0, N_INPUTS=2, correct NOR, `op`=5 → each vector held exactly 2 cycles; `done` at E0+8; `pass`=1.
- **Ignored inputs.** Pulse `start` and toggle `op` mid-run → no restart; result matches the latched op; `busy` stays high continuously.
- **Reset mid-run.** Assert `rst` during CHECK of vector 1 → next cycle all outputs 0, state IDLE; a fresh `start` then completes normally.

Source files
------------

// File: rtl/gate_bist_controller_pkg.sv
// rtl/gate_bist_controller_pkg.sv - op codes and FSM state encodings for the gate BIST controller
package gate_bist_controller_pkg;

    typedef enum logic [2:0] {
        OP_BUF  = 3'd0,
        OP_NOT  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XOR  = 3'd6,
        OP_XNOR = 3'd7
    } gate_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational reference model of the basic gate library
module gate_ref_model
    import gate_bist_controller_pkg::*;
#(
    parameter int N_INPUTS = 2
) (
    input  logic [2:0]          op,
    input  logic [N_INPUTS-1:0] vec,
    output logic                expected
);

    always_comb begin
        expected = 1'b0;
        case (op)
            OP_BUF:  expected = vec[0];
            OP_NOT:  expected = ~vec[0];
            OP_AND:  expected = &vec;
            OP_OR:   expected = |vec;
            OP_NAND: expected = ~&vec;
            OP_NOR:  expected = ~|vec;
            OP_XOR:  expected = ^vec;
            OP_XNOR: expected = ~^vec;
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_bist_controller.sv
// rtl/gate_bist_controller.sv - exhaustive-vector BIST sequencer for one gate under test
module gate_bist_controller
    import gate_bist_controller_pkg::*;
#(
    parameter int N_INPUTS = 2,
    parameter int SETTLE   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          op,
    output logic [N_INPUTS-1:0] gate_in,
    input  logic                gate_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   fail_count,
    output logic [N_INPUTS-1:0] first_fail_vec
);

    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    bist_state_e         state, state_n;
    logic [2:0]          op_q, op_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [N_INPUTS-1:0] gate_in_n, first_fail_vec_n;
    logic [N_INPUTS:0]   fail_count_n;
    logic                busy_n, done_n, pass_n;
    logic                expected, mismatch;

    gate_ref_model #(.N_INPUTS(N_INPUTS)) u_ref (
        .op       (op_q),
        .vec      (gate_in),
        .expected (expected)
    );

    assign mismatch = (gate_out != expected);

    always_comb begin
        state_n          = state;
        op_n             = op_q;
        cnt_n            = cnt;
        gate_in_n        = gate_in;
        fail_count_n     = fail_count;
        first_fail_vec_n = first_fail_vec;
        busy_n           = busy;
        done_n           = 1'b0;
        pass_n           = pass;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    op_n             = op;
                    gate_in_n        = '0;
                    cnt_n            = '0;
                    fail_count_n     = '0;
                    first_fail_vec_n = '0;
                    pass_n           = 1'b0;
                    busy_n           = 1'b1;
                    state_n          = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == CW'(SETTLE)) begin
                    state_n = ST_CHECK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    fail_count_n = fail_count + 1'b1;
                    if (fail_count == '0) begin
                        first_fail_vec_n = gate_in;
                    end
                end
                if (&gate_in) begin
                    // pass is resolved here so it is already valid while done is high
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                    pass_n  = (fail_count == '0) && !mismatch;
                end else begin
                    gate_in_n = gate_in + 1'b1;
                    cnt_n     = '0;
                    state_n   = ST_SETTLE;
                end
            end
            ST_DONE: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            op_q           <= '0;
            cnt            <= '0;
            gate_in        <= '0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state          <= state_n;
            op_q           <= op_n;
            cnt            <= cnt_n;
            gate_in        <= gate_in_n;
            fail_count     <= fail_count_n;
            first_fail_vec <= first_fail_vec_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
        end
    end

endmodule

// File: tb/tb_gate_bist_controller.sv
// tb/tb_gate_bist_controller.sv - scoreboard bench for gate_bist_controller with injectable gate faults
module tb_gate_bist_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st_req = 1'b0;
    logic       sel = 1'b0;
    logic [2:0] op = 3'd0;
    logic [2:0] gut_op = 3'd0;
    int         fault = 0;

    logic       start, start0;
    logic [2:0] gate_in;
    logic [1:0] gate_in0;
    logic       gate_out, gate_out0;
    logic       busy, done, pass, busy0, done0, pass0;
    logic [3:0] fail_count;
    logic [2:0] fail_count0;
    logic [2:0] first_fail_vec;
    logic [1:0] first_fail_vec0;

    logic       o_busy, o_done, o_pass;
    logic [3:0] o_fc;
    logic [2:0] o_ffv, o_gin;

    typedef struct {
        logic       pass;
        logic [3:0] fc;
        logic [2:0] ffv;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    // ones-count formulation of each gate, deliberately not a reduction operator
    function automatic logic golden(input logic [2:0] o, input logic [7:0] v, input int n);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(v[i]);
        case (o)
            3'd0: return v[0];
            3'd1: return !v[0];
            3'd2: return ones == n;
            3'd3: return ones != 0;
            3'd4: return ones != n;
            3'd5: return ones == 0;
            3'd6: return ones % 2 == 1;
            default: return ones % 2 == 0;
        endcase
    endfunction

    // fault 0 good gate, 1 stuck-at-0, 2 inverted, 3 stuck-at-1
    function automatic logic gut(input logic [2:0] o, input logic [7:0] v, input int n, input int f);
        case (f)
            1: return 1'b0;
            2: return !golden(o, v, n);
            3: return 1'b1;
            default: return golden(o, v, n);
        endcase
    endfunction

    assign start     = sel ? 1'b0 : st_req;
    assign start0    = sel ? st_req : 1'b0;
    assign gate_out  = gut(gut_op, {5'b0, gate_in}, 3, fault);
    assign gate_out0 = gut(gut_op, {6'b0, gate_in0}, 2, fault);

    always_comb begin
        o_busy = sel ? busy0 : busy;
        o_done = sel ? done0 : done;
        o_pass = sel ? pass0 : pass;
        o_fc   = sel ? {1'b0, fail_count0} : fail_count;
        o_ffv  = sel ? {1'b0, first_fail_vec0} : first_fail_vec;
        o_gin  = sel ? {1'b0, gate_in0} : gate_in;
    end

    gate_bist_controller #(.N_INPUTS(3), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .gate_in(gate_in), .gate_out(gate_out),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count), .first_fail_vec(first_fail_vec)
    );

    gate_bist_controller #(.N_INPUTS(2), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op), .gate_in(gate_in0), .gate_out(gate_out0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_count(fail_count0), .first_fail_vec(first_fail_vec0)
    );

    task automatic run(input bit s_sel, input logic [2:0] o, input int f, input bit disturb);
        int n  = s_sel ? 2 : 3;
        int sv = s_sel ? 0 : 1;
        int nv = 1 << n;
        int nf = 0;
        int k = 1;
        int seq_err = 0;
        int busy_low = 0;
        bit got = 0;
        logic [2:0] first = '0;
        exp_t e, g;
        for (int v = 0; v < nv; v++) begin
            if (gut(o, 8'(v), n, f) != golden(o, 8'(v), n)) begin
                if (nf == 0) first = 3'(v);
                nf++;
            end
        end
        e.pass = (nf == 0); e.fc = 4'(nf); e.ffv = first; e.lat = nv * (sv + 2) + 1;
        sb.push_back(e);
        sel = s_sel; gut_op = o; fault = f;
        @(negedge clk); op = o; st_req = 1'b1;
        @(negedge clk); st_req = 1'b0;
        while (k <= 100 && !got) begin
            if (o_busy !== 1'b1) busy_low++;
            if (o_done === 1'b1) begin
                got = 1;
            end else begin
                if (o_gin !== 3'((k - 1) / (sv + 2))) seq_err++;
                if (disturb && k == 5) begin st_req = 1'b1; op = ~o; end
                if (disturb && k == 8) st_req = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        op = o; st_req = 1'b0;
        g = sb.pop_front();
        total++; if (k !== g.lat) $display("FAIL done_latency op=%0d f=%0d: got %0d expected %0d", o, f, k, g.lat); else passed++;
        total++; if (o_pass !== g.pass) $display("FAIL pass op=%0d f=%0d: got %0b expected %0b", o, f, o_pass, g.pass); else passed++;
        total++; if (o_fc !== g.fc) $display("FAIL fail_count op=%0d f=%0d: got %0d expected %0d", o, f, o_fc, g.fc); else passed++;
        total++; if (o_ffv !== g.ffv) $display("FAIL first_fail_vec op=%0d f=%0d: got %0d expected %0d", o, f, o_ffv, g.ffv); else passed++;
        total++; if (seq_err !== 0) $display("FAIL gate_in_seq op=%0d: got %0d bad cycles expected 0", o, seq_err); else passed++;
        total++; if (busy_low !== 0) $display("FAIL busy_high op=%0d: got %0d low cycles expected 0", o, busy_low); else passed++;
        @(negedge clk);
        total++; if (o_done !== 1'b0) $display("FAIL done_pulse op=%0d: got %0b expected 0", o, o_done); else passed++;
        total++; if (o_busy !== 1'b0) $display("FAIL busy_fall op=%0d: got %0b expected 0", o, o_busy); else passed++;
        total++; if (o_pass !== g.pass) $display("FAIL pass_hold op=%0d: got %0b expected %0b", o, o_pass, g.pass); else passed++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({gate_in, busy, done, pass, fail_count, first_fail_vec} !== 14'd0)
            $display("FAIL reset_main: got %h expected 0", {gate_in, busy, done, pass, fail_count, first_fail_vec}); else passed++;
        total++; if ({gate_in0, busy0, done0, pass0, fail_count0, first_fail_vec0} !== 10'd0)
            $display("FAIL reset_zero_settle: got %h expected 0", {gate_in0, busy0, done0, pass0, fail_count0, first_fail_vec0}); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_correct_ops;
        for (int o = 0; o < 8; o++) run(1'b0, 3'(o), 0, 1'b0);
    endtask

    task automatic test_faults;
        run(1'b0, 3'd2, 1, 1'b0);   // stuck-at-0 AND: only 3'b111 fails
        run(1'b0, 3'd6, 2, 1'b0);   // inverted XOR: every vector fails
        run(1'b0, 3'd0, 1, 1'b0);   // stuck-at-0 BUF: odd vectors fail
        run(1'b0, 3'd2, 3, 1'b0);   // stuck-at-1 AND: all but 3'b111 fail
    endtask

    task automatic test_zero_settle;
        run(1'b1, 3'd5, 0, 1'b0);
        run(1'b1, 3'd6, 2, 1'b0);
        run(1'b1, 3'd1, 0, 1'b0);
    endtask

    task automatic test_ignored_inputs;
        run(1'b0, 3'd3, 0, 1'b1);
        run(1'b0, 3'd4, 1, 1'b1);
    endtask

    task automatic test_reset_mid_run;
        sel = 1'b0; gut_op = 3'd3; fault = 0;
        @(negedge clk); op = 3'd3; st_req = 1'b1;
        @(negedge clk); st_req = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (gate_in !== 3'd0) $display("FAIL rst_mid gate_in: got %0d expected 0", gate_in); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid busy: got %0b expected 0", busy); else passed++;
        total++; if ({done, pass} !== 2'b00) $display("FAIL rst_mid done_pass: got %b expected 00", {done, pass}); else passed++;
        total++; if ({fail_count, first_fail_vec} !== 7'd0) $display("FAIL rst_mid counts: got %h expected 0", {fail_count, first_fail_vec}); else passed++;
        run(1'b0, 3'd7, 2, 1'b0);
    endtask

    task automatic test_back_to_back;
        run(1'b0, 3'd5, 0, 1'b0);
        run(1'b0, 3'd1, 2, 1'b0);
    endtask

    initial begin
        test_reset;
        test_correct_ops;
        test_faults;
        test_zero_settle;
        test_ignored_inputs;
        test_reset_mid_run;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
